// File: rtl/pixel_readout_ctrl_if.sv
// Pixel stream handshake between the readout controller and the frame consumer.
// The controller holds data/flags stable until out_ready accepts the beat.
interface pixel_readout_ctrl_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_first;
  logic       out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_first,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_first,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/pixel_readout_ctrl.sv
// Pixel sensor sequencer (erase/expose/convert) plus 4-to-1 mux scan to a stream.
// Optional test pattern source: define PIXEL_READOUT_TESTPAT_EN.
module pixel_readout_ctrl #(
  parameter int ERASE_CYCLES   = 5,
  parameter int EXPOSE_CYCLES  = 255,
  parameter int CONVERT_CYCLES = 255,
  parameter int NUM_PIXELS     = 4,
  parameter int SEL_W          = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef PIXEL_READOUT_TESTPAT_EN
  input  logic             test_mode,
`endif
  output logic             erase,
  output logic             expose,
  output logic             convert,
  output logic [SEL_W-1:0] pix_sel,
  input  logic [7:0]       pix_data,
  pixel_readout_ctrl_if.master stream,
  output logic             busy,
  output logic             frame_done
);

  localparam int M1 = (ERASE_CYCLES > EXPOSE_CYCLES) ?
                      ERASE_CYCLES : EXPOSE_CYCLES;
  localparam int MAXC = (M1 > CONVERT_CYCLES) ? M1 : CONVERT_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam int IW = SEL_W + 1;

  typedef enum logic [2:0] {
    IDLE, ERASE, EXPOSE, CONVERT, READ, DONE
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          load;
  logic          accept;
  logic [7:0]    cap;

  assign accept = stream.out_valid && stream.out_ready;

`ifdef PIXEL_READOUT_TESTPAT_EN
  logic [5:0] frame_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_cnt <= '0;
    else if (state == DONE) frame_cnt <= frame_cnt + 1'b1;
  end

  assign cap = test_mode ? {frame_cnt, idx[1:0]} : pix_data;
`else
  assign cap = pix_data;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    unique case (state)
      IDLE:    if (start) state_n = ERASE;
      ERASE:   if (cnt == CW'(ERASE_CYCLES - 1)) state_n = EXPOSE;
      EXPOSE:  if (cnt == CW'(EXPOSE_CYCLES - 1)) state_n = CONVERT;
      CONVERT: if (cnt == CW'(CONVERT_CYCLES - 1)) state_n = READ;
      READ: begin
        load = (idx < IW'(NUM_PIXELS)) &&
               (!stream.out_valid || stream.out_ready);
        if (idx == IW'(NUM_PIXELS) && accept) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Phase strobes and status are registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      erase            <= 1'b0;
      expose           <= 1'b0;
      convert          <= 1'b0;
      busy             <= 1'b0;
      frame_done       <= 1'b0;
      cnt              <= '0;
      idx              <= '0;
      pix_sel          <= '0;
      stream.out_data  <= '0;
      stream.out_valid <= 1'b0;
      stream.out_first <= 1'b0;
      stream.out_last  <= 1'b0;
    end else begin
      erase      <= (state_n == ERASE);
      expose     <= (state_n == EXPOSE);
      convert    <= (state_n == CONVERT);
      busy       <= (state_n != IDLE);
      frame_done <= (state_n == DONE);
      cnt        <= (state_n != state) ? '0 : cnt + 1'b1;
      if (state == CONVERT && state_n == READ) begin
        idx     <= '0;
        pix_sel <= '0;
      end else if (load) begin
        stream.out_data  <= cap;
        stream.out_valid <= 1'b1;
        stream.out_first <= (idx == '0);
        stream.out_last  <= (idx == IW'(NUM_PIXELS - 1));
        idx              <= idx + 1'b1;
        pix_sel          <= pix_sel + 1'b1;
      end else if (accept) begin
        stream.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pixel_readout_ctrl.sv
// Scoreboard bench for pixel_readout_ctrl with short phase parameters.
// Expected beats are queued at frame start and popped on each accepted beat.
module tb_pixel_readout_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       erase, expose, convert, busy, frame_done;
  logic [1:0] pix_sel;
  logic [7:0] pix_data;
`ifdef PIXEL_READOUT_TESTPAT_EN
  logic       test_mode = 1'b0;
`endif

  pixel_readout_ctrl_if sif ();

  assign pix_data = 8'h10 + {6'd0, pix_sel};

  pixel_readout_ctrl #(
    .ERASE_CYCLES  (2),
    .EXPOSE_CYCLES (3),
    .CONVERT_CYCLES(2),
    .NUM_PIXELS    (4),
    .SEL_W         (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
`ifdef PIXEL_READOUT_TESTPAT_EN
    .test_mode (test_mode),
`endif
    .erase     (erase),
    .expose    (expose),
    .convert   (convert),
    .pix_sel   (pix_sel),
    .pix_data  (pix_data),
    .stream    (sif),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       f;
    logic       l;
  } beat_t;

  beat_t q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fd_cnt = 0;
  int fd_cyc = 0;
  int last_acc = 0;
  int read_entry = 0;
  int erase_rises = 0;
  int elen = 0, xlen = 0, clen = 0;
  logic pe = 0, px = 0, pc = 0, pv = 0, pf = 0;
  logic hold = 0;
  logic [7:0] hold_d;
  logic [1:0] hold_s;
  bit thru = 0, gap_armed = 0, b2b = 0, lat_armed = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk(tag, {erase, expose, convert, pix_sel, sif.out_data,
              sif.out_valid, sif.out_first, sif.out_last,
              busy, frame_done}, 0);
  endtask

  task automatic push_frame(input logic [7:0] base);
    beat_t b;
    for (int i = 0; i < 4; i++) begin
      b.d = base + 8'(i);
      b.f = (i == 0);
      b.l = (i == 3);
      q.push_back(b);
    end
  endtask

  task automatic observe();
    beat_t e;
    cyc++;
    chk("phase_onehot", ($countones({erase, expose, convert}) <= 1), 1);
    if (erase) elen++;
    else if (elen != 0) begin chk("erase_len", elen, 2); elen = 0; end
    if (expose) xlen++;
    else if (xlen != 0) begin chk("expose_len", xlen, 3); xlen = 0; end
    if (convert) clen++;
    else if (clen != 0) begin chk("convert_len", clen, 2); clen = 0; end
    if (expose && !px) chk("erase_to_expose", pe, 1);
    if (convert && !pc) chk("expose_to_convert", px, 1);
    if (!convert && pc) begin read_entry = cyc; lat_armed = 1; end
    if (erase && !pe) begin
      erase_rises++;
      if (gap_armed) begin
        chk("idle_gap", cyc - fd_cyc, 2);
        gap_armed = 0;
      end
    end
    if (sif.out_valid && !pv && lat_armed) begin
      chk("first_latency", cyc - read_entry, 1);
      lat_armed = 0;
    end
    if (hold) begin
      chk("valid_held", sif.out_valid, 1);
      chk("hold_data", sif.out_data, hold_d);
      chk("hold_sel", pix_sel, hold_s);
    end
    hold   = sif.out_valid && !sif.out_ready;
    hold_d = sif.out_data;
    hold_s = pix_sel;
    if (sif.out_valid && sif.out_ready) begin
      if (q.size() == 0) begin
        chk("extra_beat", 1, 0);
      end else begin
        e = q.pop_front();
        chk("beat_data", sif.out_data, e.d);
        chk("beat_first", sif.out_first, e.f);
        chk("beat_last", sif.out_last, e.l);
        if (thru && !sif.out_first) chk("thruput", cyc - last_acc, 1);
      end
      last_acc = cyc;
    end
    if (pf) chk("busy_after_done", busy, 0);
    if (frame_done) begin
      fd_cnt++;
      chk("done_after_last", cyc - last_acc, 1);
      chk("done_valid_low", sif.out_valid, 0);
      fd_cyc = cyc;
      if (b2b) gap_armed = 1;
    end
    pe = erase; px = expose; pc = convert;
    pv = sif.out_valid; pf = frame_done;
  endtask

  // Inputs change at the falling edge; observation happens 1ns before rise.
  task automatic cycle();
    #4;
    observe();
    @(negedge clk);
  endtask

  task automatic run_until(input int target, input int budget);
    int n = 0;
    while (fd_cnt < target && n < budget) begin cycle(); n++; end
    if (fd_cnt < target) chk("timeout_done", fd_cnt, target);
  endtask

  task automatic wait_beat(input logic [7:0] d);
    int n = 0;
    while (!(sif.out_valid && sif.out_data == d) && n < 60) begin
      cycle(); n++;
    end
    if (n >= 60) chk("timeout_beat", sif.out_data, d);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  initial begin
    int n;
    int er0;
    sif.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("reset_state");
    reset = 1'b0;
    cycle();

    // Basic frame, ready always high
    thru = 1;
    push_frame(8'h10);
    pulse_start();
    run_until(1, 100);
    chk("queue_empty_1", q.size(), 0);
    cycle();
    thru = 0;

    // Backpressure on beat 1
    push_frame(8'h10);
    pulse_start();
    wait_beat(8'h11);
    sif.out_ready = 1'b0;
    repeat (3) cycle();
    sif.out_ready = 1'b1;
    cycle();
    chk("resume_data", sif.out_data, 8'h12);
    run_until(2, 100);
    chk("queue_empty_2", q.size(), 0);

    // Start during expose is ignored
    push_frame(8'h10);
    pulse_start();
    n = 0;
    while (!expose && n < 40) begin cycle(); n++; end
    chk("saw_expose", expose, 1);
    pulse_start();
    run_until(3, 100);
    repeat (20) cycle();
    chk("single_done", fd_cnt, 3);
    chk("idle_after", busy, 0);
    chk("queue_empty_3", q.size(), 0);

    // Asynchronous reset in READ after beat 1
    push_frame(8'h10);
    pulse_start();
    wait_beat(8'h11);
    cycle();
    reset = 1'b1;
    #1;
    check_zero("async_reset");
    q.delete();
    hold = 0;
    lat_armed = 0;
    @(negedge clk);
    repeat (2) cycle();
    reset = 1'b0;
    repeat (5) cycle();
    chk("no_done_on_reset", fd_cnt, 3);
    push_frame(8'h10);
    pulse_start();
    run_until(4, 100);
    chk("queue_empty_4", q.size(), 0);
    cycle();

    // Start held high: back-to-back frames
    b2b = 1;
    thru = 1;
    er0 = erase_rises;
    push_frame(8'h10);
    push_frame(8'h10);
    start = 1'b1;
    run_until(6, 200);
    start = 1'b0;
    gap_armed = 0;
    repeat (5) cycle();
    chk("b2b_erase_rises", erase_rises - er0, 2);
    chk("b2b_frames", fd_cnt, 6);
    chk("queue_empty_5", q.size(), 0);
    b2b = 0;
    thru = 0;

`ifdef PIXEL_READOUT_TESTPAT_EN
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    pe = 0; px = 0; pc = 0; pv = 0; pf = 0; hold = 0;
    test_mode = 1'b1;
    push_frame(8'h00);
    push_frame(8'h04);
    start = 1'b1;
    run_until(8, 200);
    start = 1'b0;
    repeat (5) cycle();
    chk("testpat_frames", fd_cnt, 8);
    chk("queue_empty_tp", q.size(), 0);
    test_mode = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_readout_ctrl.md
Name: pixel_readout_ctrl

Overview:
- Sequencer and stream stage wrapped around the 4-to-1 pixel mux.
- On start, drives the pixel sensors through erase, expose and convert phases, then scans the mux select 0..3.
- Captures each selected 8-bit pixel into a registered output with a valid/ready handshake. This handshake feeds the downstream frame consumer.

Parameters:
- ERASE_CYCLES, 5, cycles erase is held high (min 1)
- EXPOSE_CYCLES, 255, cycles expose is held high (min 1)
- CONVERT_CYCLES, 255, cycles convert is held high (min 1)
- NUM_PIXELS, 4, pixels scanned per frame (must be 2**SEL_W)
- SEL_W, 2, mux select width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous active-high reset
- start  in  1  begin frame; sampled only in IDLE
- erase  out  1  pixel sensor erase
- expose  out  1  pixel sensor expose
- convert  out  1  pixel sensor ADC convert
- pix_sel  out  SEL_W  registered mux select
- pix_data  in  8  mux output, combinational from pix_sel
- out_data  out  8  captured pixel value
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts when high with out_valid
- out_first  out  1  qualifies pixel 0 of a frame
- out_last  out  1  qualifies pixel NUM_PIXELS-1
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse after last pixel accepted

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; phase counter=0; pixel index=0.
- FSM states: IDLE, ERASE, EXPOSE, CONVERT, READ, DONE.
- IDLE:
  - start=1 at an edge -> ERASE at that edge.
  - start while busy is ignored.
- ERASE / EXPOSE / CONVERT:
  - The matching output (erase/expose/convert) is registered and high for exactly N cycles (N = the phase parameter).
  - Phases are back-to-back with no gap; exactly one of the three is high at a time.
  - Phase counter width is $clog2(max param+1); it restarts at 0 on each phase entry.
- Transition CONVERT->READ: pix_sel=0, index=0.
- READ capture rule, evaluated each cycle: load = (index<NUM_PIXELS) && (!out_valid || out_ready). On load at the edge:
  - out_data<=pix_data; out_valid<=1.
  - out_first<=(index==0); out_last<=(index==NUM_PIXELS-1).
  - index<=index+1; pix_sel<=pix_sel+1 (wraps to 0 after the last pixel).
- Throughput and latency:
  - With out_ready held high: one pixel per cycle.
  - First out_valid appears 1 cycle after READ entry.
- Backpressure:
  - While out_valid && !out_ready, out_data/out_first/out_last/pix_sel hold stable.
  - out_valid is never withdrawn before acceptance.
- Acceptance without reload: out_valid<=0.
- READ exit: once index==NUM_PIXELS and the last beat is accepted -> DONE.
- DONE: frame_done=1 for one cycle, out_valid=0 -> IDLE. busy is 0 from the IDLE cycle on.
- New frame: start high in the IDLE cycle after DONE begins a new frame. The minimum frame-to-frame gap is therefore 1 IDLE cycle.
- Reset mid-frame: immediate return to IDLE. A partial frame is discarded; no frame_done is issued.

Optional Feature:
- Macro: PIXEL_READOUT_TESTPAT_EN.
- Defined:
  - Adds input test_mode (1 bit) and an internal 6-bit frame counter.
  - The frame counter is reset to 0 and incremented on each DONE; it wraps at 63->0.
  - With test_mode=1, captured data = {frame_cnt[5:0], index[1:0]} instead of pix_data. All timing is unchanged.
- Undefined: no test_mode port, no frame counter; data always comes from pix_data.

Test Plan:
- Bench params ERASE=2, EXPOSE=3, CONVERT=2; pix_data modelled as 8'h10+pix_sel:
  - start pulse -> erase high for 2 cycles, expose for 3, convert for 2, all contiguous.
  - Then out_data 8'h10,11,12,13 on 4 consecutive cycles with out_ready=1.
  - first/last flags on beats 0/3; frame_done one cycle after beat 3; busy=0 afterward.
- Backpressure: out_ready low for 3 cycles while beat 1 is valid -> out_data=8'h11 and pix_sel stable; resumes 8'h12 the cycle after ready rises; no pixel lost or duplicated.
- start pulsed during EXPOSE -> ignored; exactly 4 beats and one frame_done produced.
- reset asserted mid-READ after beat 1 -> all outputs 0 asynchronously; no frame_done; next start yields a full 8'h10..13 frame.
- start held high continuously -> back-to-back frames, each with erase re-asserted; exactly one IDLE cycle between frame_done and the next erase.
- With PIXEL_READOUT_TESTPAT_EN and test_mode=1 -> frame 0 data 8'h00..03, frame 1 data 8'h04..07.
